iopmp_pipe_checker: RTL



---
 rtl/iopmp_pkg.sv | 29 ++
 rtl/iopmp_entry_match.sv | 38 +++
 rtl/iopmp_pipe_checker.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/iopmp_pkg.sv
// Shared types for the IOPMP permission checker: access kinds, entry address
// modes, cfg byte layout and checker FSM states.
package iopmp_pkg;

   typedef enum logic [1:0] {
      ACCESS_NONE  = 2'd0,
      ACCESS_READ  = 2'd1,
      ACCESS_WRITE = 2'd2
   } iopmp_access_t;

   typedef enum logic [1:0] {
      A_OFF   = 2'd0,
      A_TOR   = 2'd1,
      A_NA4   = 2'd2,
      A_NAPOT = 2'd3
   } iopmp_amode_t;

   localparam int CFG_R    = 0;
   localparam int CFG_W    = 1;
   localparam int CFG_A_LO = 3;
   localparam int CFG_A_HI = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_RESP = 2'd2
   } iopmp_state_t;

endpackage

// File: rtl/iopmp_entry_match.sv
// Combinational address match for a single IOPMP entry (OFF/TOR/NA4/NAPOT).
// Permission bits are not looked at here; the checker applies them to the winner.
module iopmp_entry_match
   import iopmp_pkg::*;
#(
   parameter int IOPMP_LEN = 54
) (
   input  logic [IOPMP_LEN-1:0] a_i,
   input  logic [IOPMP_LEN-1:0] e_i,
   input  logic [IOPMP_LEN-1:0] prev_i,
   input  logic [7:0]           cfg_i,
   output logic                 match_o
);

   localparam logic [IOPMP_LEN-1:0] ONE = IOPMP_LEN'(1);

   iopmp_amode_t         amode;
   logic [IOPMP_LEN-1:0] napot_care;
   logic                 unused_cfg;

   assign amode      = iopmp_amode_t'(cfg_i[CFG_A_HI:CFG_A_LO]);
   assign unused_cfg = ^{cfg_i[7:5], cfg_i[2:0]};

   // e ^ (e+1) covers the trailing-ones run plus the first zero: those are don't-care bits.
   assign napot_care = ~(e_i ^ (e_i + ONE));

   always_comb begin
      match_o = 1'b0;
      case (amode)
         A_OFF:   match_o = 1'b0;
         A_TOR:   match_o = (prev_i <= a_i) && (a_i < e_i);
         A_NA4:   match_o = (a_i == e_i);
         A_NAPOT: match_o = ((a_i ^ e_i) & napot_care) == '0;
         default: match_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/iopmp_pipe_checker.sv
// Multi-cycle IOPMP checker: scans ENTRIES_PER_CYCLE entries per clock in index
// order, answers allow/deny per handshake and keeps a sticky first-error record.
module iopmp_pipe_checker
   import iopmp_pkg::*;
#(
   parameter int PLEN              = 56,
   parameter int IOPMP_LEN         = 54,
   parameter int NR_MD             = 2,
   parameter int NR_ENTRIES_PER_MD = 8,
   parameter int NR_MASTERS        = 2,
   parameter int ENTRIES_PER_CYCLE = 4,
   localparam int NR_ENTRIES = NR_MD * NR_ENTRIES_PER_MD,
   localparam int SID_W      = (NR_MASTERS > 1) ? $clog2(NR_MASTERS) : 1,
   localparam int IDX_W      = $clog2(NR_ENTRIES)
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            enable_i,
   input  logic [NR_MASTERS*NR_MD-1:0]     srcmd_i,
   input  logic [NR_ENTRIES*IOPMP_LEN-1:0] entry_addr_i,
   input  logic [NR_ENTRIES*8-1:0]         entry_cfg_i,
   input  logic                            req_valid_i,
   output logic                            req_ready_o,
   input  logic [PLEN-1:0]                 req_addr_i,
   input  logic [SID_W-1:0]                req_sid_i,
   input  iopmp_access_t                   req_type_i,
   output logic                            rsp_valid_o,
   input  logic                            rsp_ready_i,
   output logic                            rsp_allow_o,
   output logic                            rsp_hit_o,
   output logic [IDX_W-1:0]                rsp_idx_o,
   output logic                            err_valid_o,
   output logic [PLEN-1:0]                 err_addr_o,
   output logic [SID_W-1:0]                err_sid_o,
   output iopmp_access_t                   err_type_o,
   output logic [7:0]                      err_count_o,
   input  logic                            err_clear_i
);

   localparam int NR_GROUPS = NR_ENTRIES / ENTRIES_PER_CYCLE;
   localparam int GRP_W     = (NR_GROUPS > 1) ? $clog2(NR_GROUPS) : 1;
   localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NR_GROUPS - 1);

   iopmp_state_t     state_q, state_d;
   logic             req_ready_q, req_ready_d;
   logic [PLEN-1:0]  addr_q, addr_d;
   logic [SID_W-1:0] sid_q, sid_d;
   iopmp_access_t    type_q, type_d;
   logic [NR_MD-1:0] srcmd_row_q, srcmd_row_d;
   logic [GRP_W-1:0] grp_q, grp_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_allow_q, rsp_allow_d;
   logic             rsp_hit_q, rsp_hit_d;
   logic [IDX_W-1:0] rsp_idx_q, rsp_idx_d;
   logic             err_valid_q, err_valid_d;
   logic [PLEN-1:0]  err_addr_q, err_addr_d;
   logic [SID_W-1:0] err_sid_q, err_sid_d;
   iopmp_access_t    err_type_q, err_type_d;
   logic [7:0]       err_count_q, err_count_d;

   logic [IOPMP_LEN-1:0]  entry_addr [NR_ENTRIES];
   logic [7:0]            entry_cfg  [NR_ENTRIES];
   logic [NR_MD-1:0]      srcmd_row  [NR_MASTERS];
   logic [NR_ENTRIES-1:0] entry_elig;

   for (genvar gi = 0; gi < NR_ENTRIES; gi++) begin : g_unpack
      assign entry_addr[gi] = entry_addr_i[gi*IOPMP_LEN +: IOPMP_LEN];
      assign entry_cfg[gi]  = entry_cfg_i[gi*8 +: 8];
      assign entry_elig[gi] = srcmd_row_q[gi / NR_ENTRIES_PER_MD];
   end

   for (genvar gi = 0; gi < NR_MASTERS; gi++) begin : g_srcmd
      assign srcmd_row[gi] = srcmd_i[gi*NR_MD +: NR_MD];
   end

   logic [ENTRIES_PER_CYCLE-1:0] lane_match;
   logic [IDX_W-1:0]             lane_idx [ENTRIES_PER_CYCLE];

   for (genvar gi = 0; gi < ENTRIES_PER_CYCLE; gi++) begin : g_lane
      logic [IDX_W-1:0]     prev_idx;
      logic [IOPMP_LEN-1:0] prev_addr;
      logic                 raw_match;

      assign lane_idx[gi] = IDX_W'(grp_q) * IDX_W'(ENTRIES_PER_CYCLE) + IDX_W'(gi);
      assign prev_idx     = lane_idx[gi] - IDX_W'(1);
      // TOR's lower bound for entry 0 is address zero.
      assign prev_addr    = (lane_idx[gi] == '0) ? '0 : entry_addr[prev_idx];

      iopmp_entry_match #(
         .IOPMP_LEN (IOPMP_LEN)
      ) u_match (
         .a_i     (addr_q[PLEN-1:2]),
         .e_i     (entry_addr[lane_idx[gi]]),
         .prev_i  (prev_addr),
         .cfg_i   (entry_cfg[lane_idx[gi]]),
         .match_o (raw_match)
      );

      assign lane_match[gi] = raw_match & entry_elig[lane_idx[gi]];
   end

   logic             hit_found;
   logic [IDX_W-1:0] hit_idx;
   logic [7:0]       hit_cfg;

   always_comb begin
      hit_found = 1'b0;
      hit_idx   = '0;
      hit_cfg   = '0;
      for (int k = ENTRIES_PER_CYCLE - 1; k >= 0; k--) begin
         if (lane_match[k]) begin
            hit_found = 1'b1;
            hit_idx   = lane_idx[k];
            hit_cfg   = entry_cfg[lane_idx[k]];
         end
      end
   end

   always_comb begin
      logic deny;
      logic hit_allow;
      deny        = 1'b0;
      hit_allow   = ((type_q == ACCESS_READ)  && hit_cfg[CFG_R]) ||
                    ((type_q == ACCESS_WRITE) && hit_cfg[CFG_W]);
      state_d     = state_q;
      addr_d      = addr_q;
      sid_d       = sid_q;
      type_d      = type_q;
      srcmd_row_d = srcmd_row_q;
      grp_d       = grp_q;
      rsp_valid_d = rsp_valid_q;
      rsp_allow_d = rsp_allow_q;
      rsp_hit_d   = rsp_hit_q;
      rsp_idx_d   = rsp_idx_q;
      err_valid_d = err_valid_q;
      err_addr_d  = err_addr_q;
      err_sid_d   = err_sid_q;
      err_type_d  = err_type_q;
      err_count_d = err_count_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               addr_d      = req_addr_i;
               sid_d       = req_sid_i;
               type_d      = req_type_i;
               srcmd_row_d = srcmd_row[req_sid_i];
               grp_d       = '0;
               if (!enable_i || (req_type_i == ACCESS_NONE)) begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_allow_d = !enable_i;
                  rsp_hit_d   = 1'b0;
                  rsp_idx_d   = '0;
               end else begin
                  state_d = ST_SCAN;
               end
            end
         end
         ST_SCAN: begin
            if (hit_found) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_allow_d = hit_allow;
               rsp_hit_d   = 1'b1;
               rsp_idx_d   = hit_idx;
               deny        = !hit_allow;
            end else if (grp_q == LAST_GRP) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_allow_d = 1'b0;
               rsp_hit_d   = 1'b0;
               rsp_idx_d   = '0;
               deny        = 1'b1;
            end else begin
               grp_d = grp_q + GRP_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Clear takes effect first so a same-cycle denial starts a fresh record.
      if (err_clear_i) begin
         err_valid_d = 1'b0;
         err_count_d = '0;
      end
      if (deny) begin
         if (!err_valid_d) begin
            err_valid_d = 1'b1;
            err_addr_d  = addr_q;
            err_sid_d   = sid_q;
            err_type_d  = type_q;
         end else if (err_count_d != 8'hFF) begin
            err_count_d = err_count_d + 8'd1;
         end
      end

      req_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         req_ready_q <= 1'b1;
         addr_q      <= '0;
         sid_q       <= '0;
         type_q      <= ACCESS_NONE;
         srcmd_row_q <= '0;
         grp_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_allow_q <= 1'b0;
         rsp_hit_q   <= 1'b0;
         rsp_idx_q   <= '0;
         err_valid_q <= 1'b0;
         err_addr_q  <= '0;
         err_sid_q   <= '0;
         err_type_q  <= ACCESS_NONE;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         addr_q      <= addr_d;
         sid_q       <= sid_d;
         type_q      <= type_d;
         srcmd_row_q <= srcmd_row_d;
         grp_q       <= grp_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_allow_q <= rsp_allow_d;
         rsp_hit_q   <= rsp_hit_d;
         rsp_idx_q   <= rsp_idx_d;
         err_valid_q <= err_valid_d;
         err_addr_q  <= err_addr_d;
         err_sid_q   <= err_sid_d;
         err_type_q  <= err_type_d;
         err_count_q <= err_count_d;
      end
   end

   assign req_ready_o = req_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_allow_o = rsp_allow_q;
   assign rsp_hit_o   = rsp_hit_q;
   assign rsp_idx_o   = rsp_idx_q;
   assign err_valid_o = err_valid_q;
   assign err_addr_o  = err_addr_q;
   assign err_sid_o   = err_sid_q;
   assign err_type_o  = err_type_q;
   assign err_count_o = err_count_q;

endmodule
